// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the NPC issue path: default register-file geometry
// and the opaque decode bundle handed from IDU to EXU.
package ysyx_23060187_pkg;

  localparam int DEF_NR_REG = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 2;

  typedef logic [63:0] payload_t;

endpackage

// File: rtl/ysyx_23060187_issue_ctrl_if.sv
// IDU -> issue controller -> EXU handshake bundle plus the WBU retire channel.
// The slave modport is the controller; the master modport is its environment.
interface ysyx_23060187_issue_ctrl_if
  import ysyx_23060187_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_rs1;
  logic [ADDR_W-1:0] dec_rs2;
  logic              dec_use_rs1;
  logic              dec_use_rs2;
  logic              dec_wen;
  logic [ADDR_W-1:0] dec_rd;
  payload_t          dec_payload;

  logic              iss_valid;
  logic              iss_ready;
  logic              iss_wen;
  logic [ADDR_W-1:0] iss_rd;
  payload_t          iss_payload;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_wen, dec_rd, dec_payload,
    output dec_ready,
    output iss_valid, iss_wen, iss_rd, iss_payload,
    input  iss_ready,
    input  wb_valid, wb_rd
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_wen, dec_rd, dec_payload,
    input  dec_ready,
    input  iss_valid, iss_wen, iss_rd, iss_payload,
    output iss_ready,
    output wb_valid, wb_rd
  );

endinterface

// File: rtl/ysyx_23060187_scoreboard.sv
// Per-register pending-write counters: one reserve port, two retire ports
// (WBU writeback and flushed entry), busy/full lookups and a sticky underflow flag.
module ysyx_23060187_scoreboard
  import ysyx_23060187_pkg::*;
#(
  parameter int NR_REG = DEF_NR_REG,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_idx,
  input  logic              dec_a_en,
  input  logic [ADDR_W-1:0] dec_a_idx,
  input  logic              dec_b_en,
  input  logic [ADDR_W-1:0] dec_b_idx,
  input  logic [ADDR_W-1:0] rd_a_idx,
  input  logic [ADDR_W-1:0] rd_b_idx,
  input  logic [ADDR_W-1:0] rd_c_idx,
  output logic              busy_a,
  output logic              busy_b,
  output logic              full_c,
  output logic              sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NR_REG];
  logic [CNT_W-1:0] cnt_d [NR_REG];
  logic             sb_err_q, sb_err_d;

  always_comb begin
    logic [CNT_W:0] sum;
    logic [1:0]     ndec;
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    sum      = '0;
    ndec     = '0;
    sb_err_d = sb_err_q;
    cnt_d[0] = '0;
    for (int r = 1; r < NR_REG; r++) begin
      sum  = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc_en && (inc_idx == ADDR_W'(r)));
      ndec = 2'(dec_a_en && (dec_a_idx == ADDR_W'(r)))
           + 2'(dec_b_en && (dec_b_idx == ADDR_W'(r)));
      // Retires beyond the pending count floor at zero and flag the imbalance.
      if (sum >= (CNT_W+1)'(ndec)) begin
        cnt_d[r] = CNT_W'(sum - (CNT_W+1)'(ndec));
      end else begin
        cnt_d[r] = '0;
        sb_err_d = 1'b1;
      end
    end
  end

  // NOTE: the counter array is reset, not just the flag -- busy() must read 0 right after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NR_REG; r++) cnt_q[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      for (int r = 0; r < NR_REG; r++) cnt_q[r] <= cnt_d[r];
      sb_err_q <= sb_err_d;
    end
  end

  assign busy_a = (rd_a_idx != '0) && (int'(rd_a_idx) < NR_REG) && (cnt_q[rd_a_idx] != '0);
  assign busy_b = (rd_b_idx != '0) && (int'(rd_b_idx) < NR_REG) && (cnt_q[rd_b_idx] != '0);
  assign full_c = (rd_c_idx != '0) && (int'(rd_c_idx) < NR_REG) && (cnt_q[rd_c_idx] == CNT_MAX);
  assign sb_err = sb_err_q;

endmodule

// File: rtl/ysyx_23060187_issue_ctrl.sv
// IDU->EXU issue stage: one-entry output register, scoreboard hazard stall,
// flush drop and a free-running stall-cycle counter.
module ysyx_23060187_issue_ctrl
  import ysyx_23060187_pkg::*;
#(
  parameter int NR_REG = DEF_NR_REG,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_23060187_issue_ctrl_if.slave   bus,
  input  logic                        flush,
  output logic                        sb_err,
  output logic [31:0]                 stall_cnt
);

  logic              iss_valid_q, iss_valid_d;
  logic              iss_wen_q,   iss_wen_d;
  logic [ADDR_W-1:0] iss_rd_q,    iss_rd_d;
  payload_t          iss_payload_q, iss_payload_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic busy_rs1, busy_rs2, full_rd;
  logic hazard, dec_fire, iss_fire, flush_drop;

  assign hazard = (bus.dec_use_rs1 && busy_rs1)
               || (bus.dec_use_rs2 && busy_rs2)
               || (bus.dec_wen && full_rd);

  assign bus.dec_ready = (!iss_valid_q || bus.iss_ready) && !hazard && !flush;
  assign dec_fire      = bus.dec_valid && bus.dec_ready;
  assign iss_fire      = iss_valid_q && bus.iss_ready;
  // A flushed entry that EXU accepts in the same cycle still owns its reservation.
  assign flush_drop    = flush && iss_valid_q && !bus.iss_ready && iss_wen_q && (iss_rd_q != '0);

  ysyx_23060187_scoreboard #(
    .NR_REG (NR_REG),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (dec_fire && bus.dec_wen),
    .inc_idx   (bus.dec_rd),
    .dec_a_en  (bus.wb_valid),
    .dec_a_idx (bus.wb_rd),
    .dec_b_en  (flush_drop),
    .dec_b_idx (iss_rd_q),
    .rd_a_idx  (bus.dec_rs1),
    .rd_b_idx  (bus.dec_rs2),
    .rd_c_idx  (bus.dec_rd),
    .busy_a    (busy_rs1),
    .busy_b    (busy_rs2),
    .full_c    (full_rd),
    .sb_err    (sb_err)
  );

  always_comb begin
    iss_valid_d   = iss_valid_q;
    iss_wen_d     = iss_wen_q;
    iss_rd_d      = iss_rd_q;
    iss_payload_d = iss_payload_q;
    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (dec_fire) begin
      iss_valid_d   = 1'b1;
      iss_wen_d     = bus.dec_wen;
      iss_rd_d      = bus.dec_rd;
      iss_payload_d = bus.dec_payload;
    end else if (iss_fire) begin
      iss_valid_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (bus.dec_valid && hazard) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid_q   <= 1'b0;
      iss_wen_q     <= 1'b0;
      iss_rd_q      <= '0;
      iss_payload_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      iss_valid_q   <= iss_valid_d;
      iss_wen_q     <= iss_wen_d;
      iss_rd_q      <= iss_rd_d;
      iss_payload_q <= iss_payload_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.iss_valid   = iss_valid_q;
  assign bus.iss_wen     = iss_wen_q;
  assign bus.iss_rd      = iss_rd_q;
  assign bus.iss_payload = iss_payload_q;
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_23060187_issue_ctrl.sv
// Directed scenarios with literal expectations, then randomized traffic,
// all compared every cycle against a counting reference model.
module tb_ysyx_23060187_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush;
  logic        sb_err;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_23060187_issue_ctrl_if #(.ADDR_W(5)) bus ();

  ysyx_23060187_issue_ctrl #(.NR_REG(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .sb_err    (sb_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes per register, the buffered instruction, flags.
  int          mcnt [32];
  bit          m_valid, m_wen, m_err;
  logic [4:0]  m_rd;
  logic [63:0] m_pay;
  logic [31:0] m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    bit h;
    h = 1'b0;
    if (bus.dec_use_rs1 && bus.dec_rs1 != 0 && mcnt[bus.dec_rs1] != 0) h = 1'b1;
    if (bus.dec_use_rs2 && bus.dec_rs2 != 0 && mcnt[bus.dec_rs2] != 0) h = 1'b1;
    if (bus.dec_wen && bus.dec_rd != 0 && mcnt[bus.dec_rd] == 3) h = 1'b1;
    return h;
  endfunction

  function automatic bit m_ready();
    return (!m_valid || bus.iss_ready) && !m_hazard() && !flush;
  endfunction

  task automatic m_retire(input int r);
    if (mcnt[r] == 0) m_err = 1'b1;
    else mcnt[r]--;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      m_valid = 0; m_wen = 0; m_err = 0; m_rd = '0; m_pay = '0; m_stall = '0;
    end else begin
      bit hz, fire, drop;
      hz   = m_hazard();
      fire = bus.dec_valid && m_ready();
      drop = flush && m_valid && !bus.iss_ready && m_wen && m_rd != 0;
      if (bus.dec_valid && hz) m_stall++;
      if (fire && bus.dec_wen && bus.dec_rd != 0) mcnt[bus.dec_rd]++;
      if (bus.wb_valid && bus.wb_rd != 0) m_retire(int'(bus.wb_rd));
      if (drop) m_retire(int'(m_rd));
      if (flush) m_valid = 0;
      else if (fire) begin
        m_valid = 1; m_wen = bus.dec_wen; m_rd = bus.dec_rd; m_pay = bus.dec_payload;
      end else if (m_valid && bus.iss_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("cmp_dec_ready", bus.dec_ready, m_ready());
      check("cmp_iss_valid", bus.iss_valid, m_valid);
      check("cmp_iss_wen", bus.iss_wen, m_wen);
      check("cmp_iss_rd", bus.iss_rd, m_rd);
      check("cmp_iss_payload", bus.iss_payload, m_pay);
      check("cmp_sb_err", sb_err, m_err);
      check("cmp_stall_cnt", stall_cnt, m_stall);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.dec_rs1 = '0; bus.dec_rs2 = '0;
    bus.dec_use_rs1 = 0; bus.dec_use_rs2 = 0; bus.dec_wen = 0;
    bus.dec_rd = '0; bus.dec_payload = '0;
    bus.wb_valid = 0; bus.wb_rd = '0; flush = 0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                     input bit w, input logic [4:0] rd, input logic [63:0] p);
    bus.dec_valid = 1; bus.dec_rs1 = rs1; bus.dec_rs2 = rs2;
    bus.dec_use_rs1 = u1; bus.dec_use_rs2 = u2; bus.dec_wen = w;
    bus.dec_rd = rd; bus.dec_payload = p;
  endtask

  task automatic wb(input logic [4:0] r);
    bus.wb_valid = 1; bus.wb_rd = r;
  endtask

  logic [31:0] s0;

  initial begin
    idle();
    bus.iss_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_iss_valid", bus.iss_valid, 0);
    check("rst_iss_payload", bus.iss_payload, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_sb_err", sb_err, 0);
    rst = 1;
    bus.iss_ready = 1;

    // Back-to-back independent instructions
    dec(1, 2, 1, 1, 1, 3, 64'h100); #1 check("b2b_rdy0", bus.dec_ready, 1); tick();
    check("b2b_valid0", bus.iss_valid, 1);
    check("b2b_rd0", bus.iss_rd, 3);
    dec(1, 2, 1, 1, 1, 4, 64'h101); #1 check("b2b_rdy1", bus.dec_ready, 1); tick();
    check("b2b_valid1", bus.iss_valid, 1);
    check("b2b_pay1", bus.iss_payload, 64'h101);
    dec(3, 0, 1, 0, 0, 0, 64'h102); #1 check("b2b_cnt3_busy", bus.dec_ready, 0);
    dec(0, 4, 0, 1, 0, 0, 64'h103); #1 check("b2b_cnt4_busy", bus.dec_ready, 0);
    idle(); wb(3); tick(); wb(4); tick(); idle();

    // RAW stall, released by a writeback
    dec(0, 0, 0, 0, 1, 5, 64'h200); tick();
    dec(5, 0, 1, 0, 0, 0, 64'h201); #1 check("raw_rdy", bus.dec_ready, 0);
    s0 = stall_cnt;
    tick(); check("raw_stall1", stall_cnt, s0 + 1);
    tick(); check("raw_stall2", stall_cnt, s0 + 2);
    wb(5); #1 check("raw_wb_same_cycle", bus.dec_ready, 0);
    tick(); bus.wb_valid = 0; #1 check("raw_wb_next", bus.dec_ready, 1);
    tick(); check("raw_issued", bus.iss_payload, 64'h201);
    check("raw_issued_v", bus.iss_valid, 1);
    idle(); tick();

    // EXU backpressure
    bus.iss_ready = 0;
    dec(0, 0, 0, 0, 0, 0, 64'h300); #1 check("bp_rdy", bus.dec_ready, 1); tick();
    dec(0, 0, 0, 0, 0, 0, 64'h301);
    for (int i = 0; i < 4; i++) begin
      #1 check("bp_hold_rdy", bus.dec_ready, 0);
      check("bp_hold_pay", bus.iss_payload, 64'h300);
      tick();
    end
    bus.iss_ready = 1; #1 check("bp_release_rdy", bus.dec_ready, 1); tick();
    check("bp_next_pay", bus.iss_payload, 64'h301);
    idle(); tick(); check("bp_drained", bus.iss_valid, 0);

    // WAW saturation on rd=7
    for (int i = 0; i < 3; i++) begin
      dec(0, 0, 0, 0, 1, 7, 64'h400 + 64'(i)); tick();
    end
    dec(0, 0, 0, 0, 1, 7, 64'h403); #1 check("waw_full", bus.dec_ready, 0); tick();
    wb(7); #1 check("waw_wb_same", bus.dec_ready, 0);
    tick(); bus.wb_valid = 0; #1 check("waw_wb_next", bus.dec_ready, 1);
    tick(); check("waw_issued", bus.iss_payload, 64'h403);
    idle();
    for (int i = 0; i < 3; i++) begin wb(7); tick(); end
    idle();

    // Flush of a buffered write to rd=9
    bus.iss_ready = 0;
    dec(0, 0, 0, 0, 1, 9, 64'h500); tick(); idle();
    check("fl_buffered", bus.iss_valid, 1);
    flush = 1; #1 check("fl_rdy", bus.dec_ready, 0);
    tick(); flush = 0;
    check("fl_dropped", bus.iss_valid, 0);
    check("fl_sb_err", sb_err, 0);
    dec(9, 0, 1, 0, 0, 0, 64'h501); #1 check("fl_cnt9_free", bus.dec_ready, 1); tick();
    bus.iss_ready = 1;
    for (int i = 0; i < 4; i++) begin dec(0, 0, 0, 0, 1, 0, 64'h510 + 64'(i)); tick(); end
    dec(0, 0, 1, 1, 1, 0, 64'h520); #1 check("x0_never_counted", bus.dec_ready, 1);
    tick(); idle();

    // Spurious writeback, sticky error
    wb(12); tick(); idle();
    check("spur_err", sb_err, 1);
    tick(); tick(); check("spur_sticky", sb_err, 1);

    // Asynchronous reset in the middle of a stall
    dec(0, 0, 0, 0, 1, 5, 64'h600); tick();
    dec(5, 0, 1, 0, 0, 0, 64'h601); tick(); tick();
    #3 rst = 0;
    #1;
    check("arst_valid", bus.iss_valid, 0);
    check("arst_rd", bus.iss_rd, 0);
    check("arst_wen", bus.iss_wen, 0);
    check("arst_payload", bus.iss_payload, 0);
    check("arst_stall", stall_cnt, 0);
    check("arst_err", sb_err, 0);
    idle(); tick(); rst = 1;

    // Randomized traffic on a small register window
    for (int c = 0; c < 3000; c++) begin
      int r;
      bus.dec_valid   = ($urandom_range(0, 3) != 0);
      bus.dec_rs1     = 5'($urandom_range(0, 7));
      bus.dec_rs2     = 5'($urandom_range(0, 7));
      bus.dec_use_rs1 = 1'($urandom_range(0, 1));
      bus.dec_use_rs2 = 1'($urandom_range(0, 1));
      bus.dec_wen     = ($urandom_range(0, 3) != 0);
      bus.dec_rd      = 5'($urandom_range(0, 7));
      bus.dec_payload = {$urandom, $urandom};
      bus.iss_ready   = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      r = $urandom_range(1, 7);
      bus.wb_valid    = (mcnt[r] > 0) && ($urandom_range(0, 1) == 1);
      bus.wb_rd       = 5'(r);
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060187_issue_ctrl.md
Name: ysyx_23060187_issue_ctrl

Overview:
Issue controller between IDU and EXU in the multicycle NPC. It holds one decoded instruction in an output register and forwards it to EXU with a valid/ready handshake. A per-register scoreboard of pending writes stalls issue on RAW and WAW-overflow hazards. Writeback notifications from WBU retire scoreboard entries; a flush input drops the buffered instruction.

Parameters:
NR_REG, 32, number of architectural registers (16 for an RV32E build)
ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NR_REG
CNT_W, 2, width of each pending-write counter; saturation limit is 2**CNT_W-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
dec_valid  in  1  IDU has a decoded instruction
dec_ready  out  1  controller accepts the IDU instruction this cycle
dec_rs1  in  ADDR_W  source register 1
dec_rs2  in  ADDR_W  source register 2
dec_use_rs1  in  1  instruction reads rs1
dec_use_rs2  in  1  instruction reads rs2
dec_wen  in  1  instruction writes rd
dec_rd  in  ADDR_W  destination register
dec_payload  in  64  opaque decode bundle, passed through unchanged
iss_valid  out  1  buffered instruction is presented to EXU
iss_ready  in  1  EXU accepts
iss_wen  out  1  buffered dec_wen
iss_rd  out  ADDR_W  buffered rd
iss_payload  out  64  buffered payload
wb_valid  in  1  WBU retires a register write
wb_rd  in  ADDR_W  retired register
flush  in  1  discard the buffered instruction (redirect)
sb_err  out  1  sticky: writeback arrived with a zero counter
stall_cnt  out  32  cycles with dec_valid=1 and hazard=1

Behaviour:
- Reset (rst=0, asynchronous): iss_valid=0; iss_wen, iss_rd, iss_payload=0; all counters=0; sb_err=0; stall_cnt=0.
- busy(r) = (cnt[r] != 0). Register 0 is never busy and is never counted.
- hazard = (dec_use_rs1 && busy(dec_rs1)) || (dec_use_rs2 && busy(dec_rs2)) || (dec_wen && dec_rd!=0 && cnt[dec_rd]==max).
- hazard uses registered counter values only. A writeback in the same cycle does not unblock; the stalled instruction may be accepted in the next cycle at the earliest.
- dec_ready = (!iss_valid || iss_ready) && !hazard && !flush. This is combinational. dec_ready does not depend on dec_valid.
- dec_fire = dec_valid && dec_ready. On fire, the output register loads rd, wen and payload; iss_valid=1 next cycle. Latency: one cycle from IDU to EXU.
- iss_fire = iss_valid && iss_ready with no dec_fire: iss_valid=0 next cycle. If both fire, the register reloads and iss_valid stays 1 (full throughput).
- Counter increment: dec_fire && dec_wen && dec_rd!=0 increments cnt[dec_rd]. The counter is reserved at accept, not at issue.
- Counter decrement: wb_valid && wb_rd!=0 decrements cnt[wb_rd].
- Decrement with a zero counter: cnt stays 0 and sb_err is set (cleared only by reset).
- Increment and decrement on the same register in one cycle: net count unchanged.
- Increment and decrement on different registers in one cycle: both are applied.
- Flush: iss_valid=0 next cycle, regardless of iss_ready. If the dropped entry has iss_wen=1 and iss_rd!=0, cnt[iss_rd] decrements. This combines with a same-cycle wb on the same register as a decrement of 2, floored at 0; the floor sets sb_err.
- No dec_fire occurs during flush. An iss_fire coinciding with flush is still a valid EXU accept: the counter is not decremented, and EXU is responsible for the instruction.
- Saturation: increment is never attempted at max, because hazard blocks it.
- stall_cnt: increments when dec_valid && hazard. It wraps at 2**32.
- Reset mid-operation: all state clears immediately. Outstanding WBU writebacks after reset will set sb_err. The system resets WBU together with this block.

Decomposition:
- Shared package ysyx_23060187_pkg: ADDR_W and NR_REG defaults, and the 64-bit decode payload typedef.
- One sub-module, ysyx_23060187_scoreboard: the counter array with inc and dual-dec ports, busy/full lookup for three indices, and sb_err.
- The top level contains the handshake register, hazard logic and stall counter.

Test Plan:
- Back-to-back independent instructions (rs1=1, rs2=2, rd=3, then rd=4) with iss_ready=1 -> dec_ready stays 1, iss_valid is continuous, cnt[3]=cnt[4]=1.
- RAW stall: issue rd=5, then an instruction reading rs1=5 -> dec_ready=0 and stall_cnt increments each cycle; wb_rd=5 pulsed -> accepted exactly 2 cycles after the wb pulse cycle.
- EXU backpressure: iss_ready=0 for 4 cycles -> iss_payload stays stable and dec_ready=0; release -> drains in one cycle.
- WAW saturation, CNT_W=2: three writes to rd=7 with no wb -> the 4th is stalled; one wb -> it is accepted 2 cycles after the wb pulse cycle.
- Flush with a buffered rd=9 wen=1 and iss_ready=0 -> iss_valid=0 next cycle, cnt[9] back to 0, sb_err=0; rd=0 writes never counted.
- Spurious wb_rd=12 with cnt=0 -> sb_err=1 and sticky; async reset asserted mid-stall -> all outputs 0 immediately.
